rca_mp_seq: RTL and testbench

Multi-precision add/subtract sequencer that time-shares one `rca_16` ripple-carry adder across `WORDS` 16-bit limbs.
- Captures wide operands through a valid/ready handshake.
- Issues one limb per clock, least-significant first, and chains the carry through a register.
- Presents the wide result with carry and signed-overflow flags on an output valid/ready handshake.
- Serves as the wide-arithmetic front end for blocks that need 32–128-bit adds without replicating adders.

---
 rtl/rca_mp_pkg.sv | 22 ++
 rtl/rca_16.sv | 27 ++
 rtl/rca_mp_seq.sv | 129 ++++++++++++
 tb/tb_rca_mp_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rca_mp_pkg.sv
// rca_mp_pkg
// Shared types and constants for the multi-precision add/subtract sequencer.
//   state_e   : sequencer states (IDLE, RUN, DONE)
//   LIMB_W    : width of one adder limb
//   words_ok  : legal-range check for the WORDS parameter
package rca_mp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int LIMB_W    = 16;
  localparam int WORDS_MIN = 2;
  localparam int WORDS_MAX = 8;

  function automatic bit words_ok(input int words);
    return (words >= WORDS_MIN) && (words <= WORDS_MAX);
  endfunction

endpackage

// File: rtl/rca_16.sv
// rca_16
// 16-bit ripple-carry adder, purely combinational.
//   a, b  : addends
//   c_in  : carry into bit 0
//   sum   : a + b + c_in, modulo 2^16
//   c_out : carry out of bit 15
module rca_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  // The carry ripples through a single scalar so no vector feeds back on itself.
  always_comb begin
    logic w_carry;
    w_carry = c_in;
    sum     = '0;
    for (int i = 0; i < 16; i++) begin
      sum[i]  = a[i] ^ b[i] ^ w_carry;
      w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
    end
    c_out = w_carry;
  end

endmodule

// File: rtl/rca_mp_seq.sv
// rca_mp_seq
// Multi-precision add/subtract sequencer. One rca_16 is time-shared across
// WORDS limbs, least-significant limb first, with the carry chained through a
// register between cycles.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   a, b, c_in, sub       : operands; sub=1 computes a - b, else a + b + c_in
//   out_valid / out_ready : result handshake (valid only in DONE)
//   sum, c_out, ovf       : wide result, top-limb carry, signed overflow
//   busy                  : operation in flight (RUN or DONE)
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one limb per cycle through the shared adder
// DONE  | result held until out_ready
module rca_mp_seq
  import rca_mp_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LIMB_W*WORDS-1:0] a,
  input  logic [LIMB_W*WORDS-1:0] b,
  input  logic                    c_in,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LIMB_W*WORDS-1:0] sum,
  output logic                    c_out,
  output logic                    ovf,
  output logic                    busy
);

  localparam int W     = LIMB_W * WORDS;
  localparam int IDX_W = $clog2(WORDS);

  if (!words_ok(WORDS)) begin : g_bad_words
    $error("rca_mp_seq: WORDS out of range");
  end

  state_e             r_state;
  state_e             w_state_nxt;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic               r_c_out;
  logic               r_ovf;

  logic [LIMB_W-1:0]  w_limb_a;
  logic [LIMB_W-1:0]  w_limb_b;
  logic [LIMB_W-1:0]  w_limb_sum;
  logic               w_limb_cout;
  logic               w_last;

  assign w_limb_a = r_a[int'(r_idx) * LIMB_W +: LIMB_W];
  assign w_limb_b = r_b[int'(r_idx) * LIMB_W +: LIMB_W];
  assign w_last   = (r_idx == IDX_W'(WORDS - 1));

  rca_16 u_rca_16 (
    .a     (w_limb_a),
    .b     (w_limb_b),
    .c_in  (r_carry),
    .sum   (w_limb_sum),
    .c_out (w_limb_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            // Subtract is a + ~b + 1: invert B here and seed the carry with 1.
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_sum[int'(r_idx) * LIMB_W +: LIMB_W] <= w_limb_sum;
          r_carry <= w_limb_cout;
          if (w_last) begin
            r_c_out <= w_limb_cout;
            r_ovf   <= (r_a[W-1] == r_b[W-1]) & (w_limb_sum[LIMB_W-1] != r_a[W-1]);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_rca_mp_seq.sv
module tb_rca_mp_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rca_mp_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer operands at a falling edge; returns just after the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tcin, input logic tsub);
    @(negedge clk);
    check("in_ready_before_op", in_ready, 1);
    a        = ta;
    b        = tb_v;
    c_in     = tcin;
    sub      = tsub;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts rising edges from accept until out_valid is seen; bounded.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid || lat >= 20) break;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic tsub,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf);
    start_op(ta, tb_v, tcin, tsub);
    wait_done(tag, WORDS);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_c_out"}, c_out, ecout);
    check({tag, "_ovf"}, ovf, eovf);
    check({tag, "_busy"}, busy, 1);
    finish_op(tag);
  endtask

  initial begin
    logic [W-1:0] bp_sum;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    check("rst_ovf", ovf, 0);

    run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0, 1'b1, 1'b0);
    run_op("carry_chain", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("sub_borrow", 64'h5, 64'h7, 1'b0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    // c_in must be ignored on subtract
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_op("add_cin", 64'h3FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("add_ovf", 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("mixed_limbs", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
           64'h2345_6789_ABCD_F001, 1'b0, 1'b0);

    // Backpressure: result must hold while new operands are offered.
    start_op(64'h1234_5678_9ABC_DEF0, 64'hEDCB_A987_6543_2110, 1'b0, 1'b0);
    wait_done("bp", WORDS);
    bp_sum = 64'h0000_0000_0000_0000;
    check("bp_sum_initial", sum, bp_sum);
    check("bp_c_out_initial", c_out, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a        = 64'hAAAA_0000_0000_0000 + 64'(i);
      b        = 64'h0000_5555_0000_0000 + 64'(i);
      sub      = i[1];
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum_hold", sum, bp_sum);
      check("bp_c_out_hold", c_out, 1);
      check("bp_ovf_hold", ovf, 0);
    end
    in_valid = 1'b0;
    sub      = 1'b0;
    finish_op("bp");
    @(posedge clk);
    @(negedge clk);
    check("bp_no_new_op", busy, 0);

    // Reset in the middle of RUN, with limb index at 2.
    start_op(64'h7777_7777_7777_7777, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_sum", sum, 0);
    run_op("after_rst", 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b0, 1'b0,
           64'h0002_0002_0002_0002, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
